// File: rtl/imem_loadable.sv
// Loadable instruction RAM with thread-tagged, one-cycle registered fetch.
// A byte-serial load FSM assembles words MSB-first and writes them at run time.
module imem_loadable #(
    parameter int PC_W      = 8,
    parameter int INSTR_W   = 16,
    parameter int TID_W     = 1,
    parameter     INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [PC_W-1:0]    fetch_pc_i,
    input  logic [TID_W-1:0]   fetch_tid_i,
    output logic               rsp_valid_o,
    output logic [INSTR_W-1:0] rsp_instr_o,
    output logic [PC_W-1:0]    rsp_pc_o,
    output logic [TID_W-1:0]   rsp_tid_o,
    output logic               rsp_misalign_o,
    input  logic               ld_start_i,
    input  logic [PC_W-1:0]    ld_base_i,
    input  logic [PC_W-2:0]    ld_count_i,
    input  logic               ld_byte_valid_i,
    input  logic [7:0]         ld_byte_i,
    output logic               ld_byte_ready_o,
    output logic               ld_busy_o,
    output logic               ld_done_o
);
    localparam int AW    = PC_W - 1;
    localparam int DEPTH = 1 << AW;
    localparam int BPW   = INSTR_W / 8;
    localparam int KW    = $clog2(BPW + 1);
    localparam logic [KW-1:0] K_LAST = KW'(BPW - 1);

    typedef enum logic [1:0] {IDLE, LD_HI, LD_WR, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic [INSTR_W-1:0]   asm_q, asm_d;
    logic                 mem_we;
    logic                 fetch_fire;
    logic [INSTR_W-1:0]   mem [DEPTH];

    logic                 rsp_valid_q;
    logic [INSTR_W-1:0]   rsp_instr_q;
    logic [PC_W-1:0]      rsp_pc_q;
    logic [TID_W-1:0]     rsp_tid_q;
    logic                 rsp_misalign_q;

    logic                 unused_base;
    assign unused_base = ld_base_i[0];

    assign fetch_ready_o   = (state_q == IDLE);
    assign ld_byte_ready_o = (state_q == LD_HI);
    assign ld_busy_o       = (state_q != IDLE);
    assign ld_done_o       = (state_q == DONE);
    assign fetch_fire      = fetch_valid_i && fetch_ready_o;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        asm_d   = asm_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    addr_d  = ld_base_i[PC_W-1:1];
                    cnt_d   = ld_count_i;
                    k_d     = '0;
                    state_d = (ld_count_i == '0) ? DONE : LD_HI;
                end
            end
            LD_HI: begin
                if (ld_byte_valid_i) begin
                    asm_d = INSTR_W'({asm_q, ld_byte_i});
                    k_d   = k_q + 1'b1;
                    if (k_q == K_LAST) state_d = LD_WR;
                end
            end
            LD_WR: begin
                mem_we  = 1'b1;
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                k_d     = '0;
                state_d = (cnt_q == AW'(1)) ? DONE : LD_HI;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= asm_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            k_q            <= '0;
            asm_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_instr_q    <= '0;
            rsp_pc_q       <= '0;
            rsp_tid_q      <= '0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            asm_q       <= asm_d;
            rsp_valid_q <= fetch_fire;
            if (fetch_fire) begin
                rsp_instr_q    <= mem[fetch_pc_i[PC_W-1:1]];
                rsp_pc_q       <= fetch_pc_i;
                rsp_tid_q      <= fetch_tid_i;
                rsp_misalign_q <= fetch_pc_i[0];
            end
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_instr_o    = rsp_instr_q;
    assign rsp_pc_o       = rsp_pc_q;
    assign rsp_tid_o      = rsp_tid_q;
    assign rsp_misalign_o = rsp_misalign_q;
endmodule
